// File: rtl/track_driver_box_if.sv
// Configuration-chain and track signals of one track driver box.
// master drives the chain and block/track inputs; slave is the box itself.
interface track_driver_box_if #(
   parameter int NUM_TRACKS = 4
);
   logic                  cfg_en;
   logic                  cfg_in;
   logic                  cfg_out;
   logic                  cfg_commit;
   logic                  cfg_full;
   logic                  cfg_valid;
   logic                  cfg_err;
   logic                  block_in;
   logic [NUM_TRACKS-1:0] track_in;
   logic [NUM_TRACKS-1:0] track_out;

   modport master (
      output cfg_en, cfg_in, cfg_commit, block_in, track_in,
      input  cfg_out, cfg_full, cfg_valid, cfg_err, track_out
   );

   modport slave (
      input  cfg_en, cfg_in, cfg_commit, block_in, track_in,
      output cfg_out, cfg_full, cfg_valid, cfg_err, track_out
   );
endinterface

// File: rtl/track_driver_box.sv
// Drives a logic-block output back onto routing tracks; per-track mode comes from a
// daisy-chained serial config chain that only takes effect on an explicit commit.
module track_driver_box #(
   parameter int NUM_TRACKS = 4
) (
   input logic                clk,
   input logic                rst_n,
   track_driver_box_if.slave  bus
);
   localparam int CFG_W = 2 * NUM_TRACKS;
   localparam int CNT_W = $clog2(CFG_W + 1);

   logic [CFG_W-1:0]      shift_reg;
   logic [CFG_W-1:0]      active_cfg;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  block_q;
   logic                  cfg_valid_q;
   logic                  cfg_err_q;
   logic                  full;
   logic [NUM_TRACKS-1:0] track_mux;

   assign full = (bit_cnt == CNT_W'(CFG_W));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg   <= '0;
         active_cfg  <= '0;
         bit_cnt     <= '0;
         block_q     <= 1'b0;
         cfg_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         cfg_err_q <= 1'b0;
         block_q   <= bus.block_in;
         // Shifting continues past a full load so downstream boxes still receive their bits.
         if (bus.cfg_en) begin
            shift_reg <= {bus.cfg_in, shift_reg[CFG_W-1:1]};
            if (!full) begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
         if (bus.cfg_commit) begin
            if (full && !bus.cfg_en) begin
               active_cfg  <= shift_reg;
               bit_cnt     <= '0;
               cfg_valid_q <= 1'b1;
            end else begin
               cfg_err_q <= 1'b1;
            end
         end
      end
   end

   // Mode per track: 00 pass-through, 01 block_in, 10 registered block, 11 tied low.
   always_comb begin
      track_mux = '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
         case (active_cfg[2*i +: 2])
            2'b00:   track_mux[i] = bus.track_in[i];
            2'b01:   track_mux[i] = bus.block_in;
            2'b10:   track_mux[i] = block_q;
            default: track_mux[i] = 1'b0;
         endcase
      end
   end

   assign bus.track_out = track_mux;
   assign bus.cfg_out   = shift_reg[0];
   assign bus.cfg_full  = full;
   assign bus.cfg_valid = cfg_valid_q;
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_track_driver_box.sv
// Bench for track_driver_box: a near box fed by the bench and a far box chained off its cfg_out.
module tb_track_driver_box;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   track_driver_box_if #(.NUM_TRACKS(N)) a_if ();
   track_driver_box_if #(.NUM_TRACKS(N)) b_if ();

   assign b_if.cfg_en     = a_if.cfg_en;
   assign b_if.cfg_commit = a_if.cfg_commit;
   assign b_if.cfg_in     = a_if.cfg_out;
   assign b_if.block_in   = a_if.block_in;

   track_driver_box #(.NUM_TRACKS(N)) u_near (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   track_driver_box #(.NUM_TRACKS(N)) u_far  (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   int checks = 0;
   int failures = 0;

   logic [7:0] sr_m;
   logic [7:0] act_m;
   logic       bq_m;
   logic [3:0] exp_q[$];
   logic [3:0] exp_t;
   logic [3:0] got_t;
   logic       lag_q[$];
   logic       exp_b;

   function automatic logic [3:0] exp_tracks(logic [7:0] cfg, logic [3:0] tin, logic bin, logic bq);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         case ({cfg[2*i+1], cfg[2*i]})
            2'b00:   r[i] = tin[i];
            2'b01:   r[i] = bin;
            2'b10:   r[i] = bq;
            default: r[i] = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         sr_m = '0;
         bq_m = 1'b0;
      end else begin
         bq_m = a_if.block_in;
         if (a_if.cfg_en) sr_m = {a_if.cfg_in, sr_m[7:1]};
      end
      #1;
   endtask

   task automatic shift_bit(input logic b);
      a_if.cfg_en = 1'b1;
      a_if.cfg_in = b;
      tick();
      a_if.cfg_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_if.track_in = 4'b1010;
      b_if.track_in = 4'b0000;
      a_if.cfg_en = 1'b1;
      a_if.cfg_in = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      a_if.cfg_en = 1'b0;
      a_if.cfg_in = 1'b0;
      #1;
      exp_q.push_back(4'b1010);
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL reset_track_out got=%b exp=%b", got_t, exp_t); end
      checks++;
      if (a_if.cfg_out !== 1'b0) begin failures++; $display("FAIL reset_cfg_out got=%b exp=0", a_if.cfg_out); end
      checks++;
      if (a_if.cfg_full !== 1'b0) begin failures++; $display("FAIL reset_cfg_full got=%b exp=0", a_if.cfg_full); end
      checks++;
      if (a_if.cfg_valid !== 1'b0) begin failures++; $display("FAIL reset_cfg_valid got=%b exp=0", a_if.cfg_valid); end
      checks++;
      if (a_if.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", a_if.cfg_err); end
   endtask

   task automatic test_full_load();
      logic [7:0] stream;
      logic [3:0] seq;
      stream = 8'b11_10_01_00;
      seq = 4'b0011;
      a_if.block_in = 1'b0;
      a_if.track_in = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            checks++;
            if (a_if.cfg_full !== 1'b0) begin failures++; $display("FAIL load_full_early got=%b exp=0", a_if.cfg_full); end
         end
         shift_bit(stream[i]);
      end
      checks++;
      if (a_if.cfg_full !== 1'b1) begin failures++; $display("FAIL load_full got=%b exp=1", a_if.cfg_full); end
      checks++;
      if (a_if.cfg_out !== sr_m[0]) begin failures++; $display("FAIL load_cfg_out got=%b exp=%b", a_if.cfg_out, sr_m[0]); end
      a_if.cfg_commit = 1'b1;
      #1;
      exp_q.push_back(4'b0101);
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL load_pre_commit_tracks got=%b exp=%b", got_t, exp_t); end
      tick();
      a_if.cfg_commit = 1'b0;
      act_m = stream;
      checks++;
      if (a_if.cfg_valid !== 1'b1) begin failures++; $display("FAIL load_valid got=%b exp=1", a_if.cfg_valid); end
      checks++;
      if (a_if.cfg_full !== 1'b0) begin failures++; $display("FAIL load_full_after_commit got=%b exp=0", a_if.cfg_full); end
      checks++;
      if (a_if.cfg_err !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", a_if.cfg_err); end
      exp_q.push_back(4'b0001);
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL load_tracks got=%b exp=%b", got_t, exp_t); end
      for (int i = 0; i < 4; i++) begin
         a_if.block_in = seq[i];
         #1;
         exp_q.push_back(exp_tracks(act_m, a_if.track_in, a_if.block_in, bq_m));
         got_t = a_if.track_out;
         exp_t = exp_q.pop_front();
         checks++;
         if (got_t !== exp_t) begin failures++; $display("FAIL load_toggle_%0d got=%b exp=%b", i, got_t, exp_t); end
         tick();
      end
      a_if.track_in = 4'b0100;
      #1;
      exp_q.push_back(exp_tracks(act_m, a_if.track_in, a_if.block_in, bq_m));
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL load_passthrough got=%b exp=%b", got_t, exp_t); end
   endtask

   task automatic test_early_commit();
      for (int i = 0; i < 5; i++) shift_bit(1'b1);
      checks++;
      if (a_if.cfg_full !== 1'b0) begin failures++; $display("FAIL early_full got=%b exp=0", a_if.cfg_full); end
      a_if.cfg_commit = 1'b1;
      tick();
      a_if.cfg_commit = 1'b0;
      checks++;
      if (a_if.cfg_err !== 1'b1) begin failures++; $display("FAIL early_err got=%b exp=1", a_if.cfg_err); end
      checks++;
      if (a_if.cfg_valid !== 1'b1) begin failures++; $display("FAIL early_valid got=%b exp=1", a_if.cfg_valid); end
      exp_q.push_back(exp_tracks(act_m, a_if.track_in, a_if.block_in, bq_m));
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL early_tracks got=%b exp=%b", got_t, exp_t); end
      tick();
      checks++;
      if (a_if.cfg_err !== 1'b0) begin failures++; $display("FAIL early_err_width got=%b exp=0", a_if.cfg_err); end
   endtask

   task automatic test_commit_with_shift();
      for (int i = 0; i < 3; i++) shift_bit(1'b0);
      checks++;
      if (a_if.cfg_full !== 1'b1) begin failures++; $display("FAIL cws_full got=%b exp=1", a_if.cfg_full); end
      a_if.block_in = 1'b1;
      a_if.track_in = 4'b0000;
      a_if.cfg_en = 1'b1;
      a_if.cfg_in = 1'b0;
      a_if.cfg_commit = 1'b1;
      tick();
      a_if.cfg_en = 1'b0;
      a_if.cfg_commit = 1'b0;
      checks++;
      if (a_if.cfg_err !== 1'b1) begin failures++; $display("FAIL cws_err got=%b exp=1", a_if.cfg_err); end
      checks++;
      if (a_if.cfg_full !== 1'b1) begin failures++; $display("FAIL cws_full_after got=%b exp=1", a_if.cfg_full); end
      exp_q.push_back(exp_tracks(act_m, a_if.track_in, a_if.block_in, bq_m));
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL cws_tracks_unchanged got=%b exp=%b", got_t, exp_t); end
      a_if.cfg_commit = 1'b1;
      tick();
      a_if.cfg_commit = 1'b0;
      act_m = sr_m;
      checks++;
      if (a_if.cfg_err !== 1'b0) begin failures++; $display("FAIL cws_clean_err got=%b exp=0", a_if.cfg_err); end
      exp_q.push_back(exp_tracks(act_m, a_if.track_in, a_if.block_in, bq_m));
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL cws_shift_applied got=%b exp=%b", got_t, exp_t); end
   endtask

   task automatic test_daisy_chain();
      logic [15:0] strm;
      strm = {8'h1B, 8'hE4};
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a_if.block_in = 1'b1;
      a_if.track_in = 4'b1000;
      b_if.track_in = 4'b1111;
      lag_q.delete();
      for (int k = 1; k <= 16; k++) begin
         a_if.cfg_en = 1'b1;
         a_if.cfg_in = strm[k-1];
         lag_q.push_back(strm[k-1]);
         tick();
         if (k >= 8) begin
            exp_b = lag_q.pop_front();
            checks++;
            if (a_if.cfg_out !== exp_b) begin failures++; $display("FAIL chain_lag_k%0d got=%b exp=%b", k, a_if.cfg_out, exp_b); end
         end
      end
      a_if.cfg_en = 1'b0;
      checks++;
      if (b_if.cfg_out !== strm[0]) begin failures++; $display("FAIL chain_far_out got=%b exp=%b", b_if.cfg_out, strm[0]); end
      checks++;
      if (b_if.cfg_full !== 1'b1) begin failures++; $display("FAIL chain_far_full got=%b exp=1", b_if.cfg_full); end
      a_if.cfg_commit = 1'b1;
      tick();
      a_if.cfg_commit = 1'b0;
      act_m = 8'h1B;
      exp_q.push_back(4'b1110);
      exp_q.push_back(4'b0111);
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL chain_near_tracks got=%b exp=%b", got_t, exp_t); end
      got_t = b_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL chain_far_tracks got=%b exp=%b", got_t, exp_t); end
      checks++;
      if ({a_if.cfg_valid, b_if.cfg_valid} !== 2'b11) begin failures++; $display("FAIL chain_valid got=%b%b exp=11", a_if.cfg_valid, b_if.cfg_valid); end
   endtask

   task automatic test_reset_mid();
      shift_bit(1'b1);
      shift_bit(1'b0);
      shift_bit(1'b1);
      a_if.track_in = 4'b0110;
      b_if.track_in = 4'b0011;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      act_m = 8'h00;
      exp_q.push_back(4'b0110);
      exp_q.push_back(4'b0011);
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL rmid_near_tracks got=%b exp=%b", got_t, exp_t); end
      got_t = b_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL rmid_far_tracks got=%b exp=%b", got_t, exp_t); end
      checks++;
      if ({a_if.cfg_valid, a_if.cfg_full, a_if.cfg_out, a_if.cfg_err} !== 4'b0000) begin
         failures++; $display("FAIL rmid_status got=%b%b%b%b exp=0000", a_if.cfg_valid, a_if.cfg_full, a_if.cfg_out, a_if.cfg_err);
      end
      for (int i = 0; i < 7; i++) shift_bit(1'b1);
      checks++;
      if (a_if.cfg_full !== 1'b0) begin failures++; $display("FAIL rmid_cnt7 got=%b exp=0", a_if.cfg_full); end
      shift_bit(1'b1);
      checks++;
      if (a_if.cfg_full !== 1'b1) begin failures++; $display("FAIL rmid_cnt8 got=%b exp=1", a_if.cfg_full); end
      rst_n = 1'b0;
      a_if.cfg_commit = 1'b1;
      tick();
      rst_n = 1'b1;
      a_if.cfg_commit = 1'b0;
      #1;
      checks++;
      if ({a_if.cfg_valid, a_if.cfg_err, a_if.cfg_full} !== 3'b000) begin
         failures++; $display("FAIL rmid_commit_discard got=%b%b%b exp=000", a_if.cfg_valid, a_if.cfg_err, a_if.cfg_full);
      end
      exp_q.push_back(exp_tracks(act_m, a_if.track_in, a_if.block_in, bq_m));
      got_t = a_if.track_out;
      exp_t = exp_q.pop_front();
      checks++;
      if (got_t !== exp_t) begin failures++; $display("FAIL rmid_commit_tracks got=%b exp=%b", got_t, exp_t); end
   endtask

   initial begin
      a_if.cfg_en = 1'b0;
      a_if.cfg_in = 1'b0;
      a_if.cfg_commit = 1'b0;
      a_if.block_in = 1'b0;
      a_if.track_in = '0;
      b_if.track_in = '0;
      sr_m = '0;
      act_m = '0;
      bq_m = 1'b0;
      test_reset();
      test_full_load();
      test_early_commit();
      test_commit_with_shift();
      test_daisy_chain();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1);
   end
endmodule
